// File: rtl/iob_cycle_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : iob_cycle_seq                                              |
// | Description : I/O-bus cycle sequencer. Runs a 68000-style slow cycle     |
// |               (AS/DS/VMA/E) for decoded IOCS/IACS requests and returns a |
// |               one-cycle IOACK or IOBERR to the FSB cycle controller.     |
// |               Optional WAIT-state timeout: define IOB_TIMEOUT_EN.        |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module iob_cycle_seq #(
    parameter int SETUP_CYC = 2,
    parameter int E_DIV     = 10,
    parameter int E_HIGH    = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic CLK,
    input  logic nRES,
    input  logic ASActive,
    input  logic IOCS,
    input  logic IACS,
    input  logic nWE,
    input  logic nIODTACK,
    input  logic nIOVPA,
    input  logic nIOBERR,
    output logic nIOAS,
    output logic nIODS,
    output logic IORnW,
    output logic nVMA,
    output logic E,
    output logic IOACK,
    output logic IOBERR,
    output logic IOBusy
);

    localparam int                c_ECNT_W     = (E_DIV > 1) ? $clog2(E_DIV) : 1;
    localparam logic [c_ECNT_W-1:0] c_ECNT_LAST = c_ECNT_W'(E_DIV - 1);
    localparam logic [c_ECNT_W-1:0] c_E_RISE    = c_ECNT_W'(E_DIV - E_HIGH);
    localparam logic [3:0]        c_SETUP_LOAD = 4'(SETUP_CYC);

    if (SETUP_CYC < 1 || SETUP_CYC > 15 || E_DIV < 2 || E_HIGH < 1 ||
        E_HIGH >= E_DIV || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_params
        $error("iob_cycle_seq: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_WAIT    = 3'd2,
        S_VPA1    = 3'd3,
        S_VPA2    = 3'd4,
        S_END     = 3'd5,
        S_RECOVER = 3'd6
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          setup_cnt_q, setup_cnt_d;
    logic                iornw_q, iornw_d;
    logic                iobusy_q, iobusy_d;
    logic                nioas_q, nioas_d;
    logic                niods_q, niods_d;
    logic                nvma_q, nvma_d;
    logic                ioack_q, ioack_d;
    logic                ioberr_q, ioberr_d;
    logic [c_ECNT_W-1:0] ecnt_q, ecnt_d;
    logic                e_q, e_d;
    logic [1:0]          dtack_sync_q, dtack_sync_d;
    logic [1:0]          vpa_sync_q, vpa_sync_d;
    logic [1:0]          berr_sync_q, berr_sync_d;

    logic w_dtack_seen;
    logic w_vpa_seen;
    logic w_berr_seen;
    logic w_e_wrap;
    logic w_tmo_hit;
    logic go_end;
    logic go_err;

    assign w_dtack_seen = ~dtack_sync_q[1];
    assign w_vpa_seen   = ~vpa_sync_q[1];
    assign w_berr_seen  = ~berr_sync_q[1];
    // ECnt is about to wrap: the next cycle starts a new E period with E low
    assign w_e_wrap     = (ecnt_q == c_ECNT_LAST);

    always_comb begin
        dtack_sync_d = {dtack_sync_q[0], nIODTACK};
        vpa_sync_d   = {vpa_sync_q[0], nIOVPA};
        berr_sync_d  = {berr_sync_q[0], nIOBERR};
        ecnt_d       = w_e_wrap ? '0 : ecnt_q + 1'b1;
        e_d          = (ecnt_d >= c_E_RISE);
    end

`ifdef IOB_TIMEOUT_EN
    localparam logic [8:0] c_TMO_LIMIT = 9'(TIMEOUT);
    logic [7:0] tmo_cnt_q, tmo_cnt_d;

    // Held at zero outside the waiting states, so it restarts on every WAIT entry
    always_comb begin
        tmo_cnt_d = 8'd0;
        if (state_q == S_WAIT || state_q == S_VPA1 || state_q == S_VPA2)
            tmo_cnt_d = tmo_cnt_q + 8'd1;
    end

    assign w_tmo_hit = (({1'b0, tmo_cnt_q} + 9'd1) == c_TMO_LIMIT);

    always_ff @(posedge CLK or negedge nRES) begin
        if (!nRES) tmo_cnt_q <= 8'd0;
        else       tmo_cnt_q <= tmo_cnt_d;
    end
`else
    assign w_tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        setup_cnt_d = setup_cnt_q;
        iornw_d     = iornw_q;
        iobusy_d    = iobusy_q;
        nioas_d     = nioas_q;
        niods_d     = niods_q;
        nvma_d      = nvma_q;
        ioack_d     = 1'b0;
        ioberr_d    = 1'b0;
        go_end      = 1'b0;
        go_err      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ASActive && (IOCS || IACS)) begin
                    state_d     = S_SETUP;
                    iornw_d     = nWE;
                    iobusy_d    = 1'b1;
                    setup_cnt_d = c_SETUP_LOAD;
                end
            end
            S_SETUP: begin
                if (setup_cnt_q == 4'd1) begin
                    nioas_d = 1'b0;
                    niods_d = 1'b0;
                    state_d = S_WAIT;
                end else begin
                    setup_cnt_d = setup_cnt_q - 4'd1;
                end
            end
            S_WAIT: begin
                if (w_berr_seen) begin
                    go_end = 1'b1;
                    go_err = 1'b1;
                end else if (w_dtack_seen) begin
                    go_end = 1'b1;
                end else if (w_vpa_seen) begin
                    state_d = S_VPA1;
                end else if (w_tmo_hit) begin
                    go_end = 1'b1;
                    go_err = 1'b1;
                end
            end
            S_VPA1: begin
                if (w_e_wrap) begin
                    nvma_d  = 1'b0;
                    state_d = S_VPA2;
                end else if (w_tmo_hit) begin
                    go_end = 1'b1;
                    go_err = 1'b1;
                end
            end
            S_VPA2: begin
                if (w_berr_seen) begin
                    go_end = 1'b1;
                    go_err = 1'b1;
                end else if (w_e_wrap) begin
                    go_end = 1'b1;
                end else if (w_tmo_hit) begin
                    go_end = 1'b1;
                    go_err = 1'b1;
                end
            end
            S_END: begin
                state_d = S_RECOVER;
            end
            S_RECOVER: begin
                // Wait for the FSB cycle and the slave's handshake to go away
                if (!ASActive && !w_dtack_seen && !w_vpa_seen) begin
                    iobusy_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (go_end) begin
            state_d  = S_END;
            nioas_d  = 1'b1;
            niods_d  = 1'b1;
            nvma_d   = 1'b1;
            ioack_d  = ~go_err;
            ioberr_d = go_err;
        end
    end

    always_ff @(posedge CLK or negedge nRES) begin
        if (!nRES) begin
            state_q      <= S_IDLE;
            setup_cnt_q  <= 4'd0;
            iornw_q      <= 1'b1;
            iobusy_q     <= 1'b0;
            nioas_q      <= 1'b1;
            niods_q      <= 1'b1;
            nvma_q       <= 1'b1;
            ioack_q      <= 1'b0;
            ioberr_q     <= 1'b0;
            ecnt_q       <= '0;
            e_q          <= 1'b0;
            dtack_sync_q <= 2'b11;
            vpa_sync_q   <= 2'b11;
            berr_sync_q  <= 2'b11;
        end else begin
            state_q      <= state_d;
            setup_cnt_q  <= setup_cnt_d;
            iornw_q      <= iornw_d;
            iobusy_q     <= iobusy_d;
            nioas_q      <= nioas_d;
            niods_q      <= niods_d;
            nvma_q       <= nvma_d;
            ioack_q      <= ioack_d;
            ioberr_q     <= ioberr_d;
            ecnt_q       <= ecnt_d;
            e_q          <= e_d;
            dtack_sync_q <= dtack_sync_d;
            vpa_sync_q   <= vpa_sync_d;
            berr_sync_q  <= berr_sync_d;
        end
    end

    assign nIOAS  = nioas_q;
    assign nIODS  = niods_q;
    assign IORnW  = iornw_q;
    assign nVMA   = nvma_q;
    assign E      = e_q;
    assign IOACK  = ioack_q;
    assign IOBERR = ioberr_q;
    assign IOBusy = iobusy_q;

endmodule
`default_nettype wire

// File: tb/tb_iob_cycle_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_iob_cycle_seq                                           |
// | Description : Self-checking bench for iob_cycle_seq: event-time model,   |
// |               directed scenarios and randomized transactions.            |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_iob_cycle_seq;

    localparam int SETUP_CYC = 2;
    localparam int E_DIV     = 10;
    localparam int E_HIGH    = 4;
    localparam int TIMEOUT   = 255;
`ifdef IOB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic CLK = 1'b0;
    logic nRES = 1'b0;
    logic ASActive = 1'b0, IOCS = 1'b0, IACS = 1'b0, nWE = 1'b1;
    logic nIODTACK = 1'b1, nIOVPA = 1'b1, nIOBERR = 1'b1;
    logic nIOAS, nIODS, IORnW, nVMA, E, IOACK, IOBERR, IOBusy;
    logic [7:0] dut_vec;

    iob_cycle_seq #(
        .SETUP_CYC(SETUP_CYC), .E_DIV(E_DIV), .E_HIGH(E_HIGH), .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK(CLK), .nRES(nRES), .ASActive(ASActive), .IOCS(IOCS), .IACS(IACS),
        .nWE(nWE), .nIODTACK(nIODTACK), .nIOVPA(nIOVPA), .nIOBERR(nIOBERR),
        .nIOAS(nIOAS), .nIODS(nIODS), .IORnW(IORnW), .nVMA(nVMA), .E(E),
        .IOACK(IOACK), .IOBERR(IOBERR), .IOBusy(IOBusy)
    );

    always #5 CLK = ~CLK;

    assign dut_vec = {nIOAS, nIODS, IORnW, nVMA, E, IOACK, IOBERR, IOBusy};

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference model: tracks the cycle as absolute event times (capture,
    // strobe, VMA, end) and derives every output from those times.
    int   m_cyc = 0;
    int   m_strobe_t, m_end_t, m_vma_t, m_ecnt, m_ecnt_pre, m_k;
    bit   m_busy, m_err, m_vpa_mode, m_rnw;
    bit   m_dt_p, m_dt_s, m_vp_p, m_vp_s, m_be_p, m_be_s;
    bit   m_dts, m_vps, m_bes;
    logic [7:0] m_exp;

    always @(posedge CLK or negedge nRES) begin
        if (!nRES) begin
            m_busy = 0; m_err = 0; m_vpa_mode = 0; m_rnw = 1;
            m_strobe_t = 0; m_end_t = -1; m_vma_t = -1; m_ecnt = 0;
            m_dt_p = 1; m_dt_s = 1; m_vp_p = 1; m_vp_s = 1; m_be_p = 1; m_be_s = 1;
        end else begin
            m_cyc++;
            m_ecnt_pre = m_ecnt;
            m_ecnt = (m_ecnt + 1) % E_DIV;
            m_dts = m_dt_s; m_vps = m_vp_s; m_bes = m_be_s;
            m_dt_s = m_dt_p; m_vp_s = m_vp_p; m_be_s = m_be_p;
            m_dt_p = nIODTACK; m_vp_p = nIOVPA; m_be_p = nIOBERR;
            if (!m_busy) begin
                if (ASActive && (IOCS || IACS)) begin
                    m_busy = 1; m_rnw = nWE; m_vpa_mode = 0;
                    m_strobe_t = m_cyc + SETUP_CYC; m_end_t = -1; m_vma_t = -1;
                end
            end else if (m_end_t < 0) begin
                if (m_cyc > m_strobe_t) begin
                    m_k = m_cyc - m_strobe_t;
                    if (!m_vpa_mode) begin
                        if (!m_bes)                        begin m_end_t = m_cyc; m_err = 1; end
                        else if (!m_dts)                   begin m_end_t = m_cyc; m_err = 0; end
                        else if (!m_vps)                   m_vpa_mode = 1;
                        else if (TO_EN && m_k == TIMEOUT)  begin m_end_t = m_cyc; m_err = 1; end
                    end else if (m_vma_t < 0) begin
                        if (m_ecnt_pre == E_DIV - 1)       m_vma_t = m_cyc;
                        else if (TO_EN && m_k == TIMEOUT)  begin m_end_t = m_cyc; m_err = 1; end
                    end else begin
                        if (!m_bes)                        begin m_end_t = m_cyc; m_err = 1; end
                        else if (m_ecnt_pre == E_DIV - 1)  begin m_end_t = m_cyc; m_err = 0; end
                        else if (TO_EN && m_k == TIMEOUT)  begin m_end_t = m_cyc; m_err = 1; end
                    end
                end
            end else if (m_cyc > m_end_t + 1) begin
                if (!ASActive && m_dts && m_vps) m_busy = 0;
            end
        end
        m_exp = {!(m_busy && m_end_t < 0 && m_cyc >= m_strobe_t),
                 !(m_busy && m_end_t < 0 && m_cyc >= m_strobe_t),
                 m_rnw,
                 !(m_busy && m_vma_t >= 0 && m_end_t < 0),
                 (m_ecnt >= E_DIV - E_HIGH),
                 (m_busy && m_end_t == m_cyc && !m_err),
                 (m_busy && m_end_t == m_cyc && m_err),
                 m_busy};
    end

    // Compare process plus event timestamps for the directed checks
    int   cyc = 0;
    int   cap_cyc = 0, strobe_cyc = 0, vma_cyc = 0, ack_cyc = 0, berr_cyc = 0;
    int   ack_cnt = 0, berr_cnt = 0;
    logic p_nioas = 1'b1, p_nvma = 1'b1, p_busy = 1'b0;

    always @(posedge CLK) begin
        cyc++;
        #1;
        if (nRES) begin
            chk("cycle_outputs", 32'(dut_vec), 32'(m_exp));
            if (p_nioas && !nIOAS) strobe_cyc = cyc;
            if (p_nvma && !nVMA)   vma_cyc = cyc;
            if (!p_busy && IOBusy) cap_cyc = cyc;
            if (IOACK)  begin ack_cyc = cyc;  ack_cnt++;  end
            if (IOBERR) begin berr_cyc = cyc; berr_cnt++; end
        end
        p_nioas = nIOAS; p_nvma = nVMA; p_busy = IOBusy;
    end

    task automatic idle_inputs();
        ASActive = 0; IOCS = 0; IACS = 0;
        nIODTACK = 1; nIOVPA = 1; nIOBERR = 1;
    endtask

    task automatic wait_strobe(input string name);
        for (int i = 0; i < 40 && nIOAS !== 1'b0; i++) @(negedge CLK);
        chk({name, "_strobe_seen"}, 32'(nIOAS), 32'd0);
    endtask

    task automatic wait_term(input string name, input int lim);
        for (int i = 0; i < lim && !(IOACK === 1'b1 || IOBERR === 1'b1); i++) @(negedge CLK);
        chk({name, "_terminated"}, 32'(IOACK | IOBERR), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 60 && IOBusy !== 1'b0; i++) @(negedge CLK);
        chk({name, "_idle"}, 32'(IOBusy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    int         a0, b0;
    logic [1:0] sel;
    int         mode, dly;
    bit         drop;

    initial begin
        idle_inputs();
        repeat (3) @(negedge CLK);
        chk("reset_state", 32'(dut_vec), 32'h0000_00F0);
        nRES = 1;
        repeat (2) @(negedge CLK);

        // Read terminated by DTACK five cycles after strobes
        ASActive = 1; IOCS = 1; nWE = 1;
        a0 = ack_cnt; b0 = berr_cnt;
        wait_strobe("read");
        chk("read_setup_delay", strobe_cyc - cap_cyc, 2);
        repeat (4) @(negedge CLK);
        nIODTACK = 0;
        wait_term("read", 40);
        chk("read_ack_latency", ack_cyc - strobe_cyc, 7);
        chk("read_ack_count", ack_cnt - a0, 1);
        chk("read_no_berr", berr_cnt - b0, 0);
        idle_inputs();
        wait_idle("read");

        // VIA write through VPA / E-clock alignment
        @(negedge CLK);
        ASActive = 1; IOCS = 1; nWE = 0; nIOVPA = 0;
        a0 = ack_cnt;
        wait_strobe("vpa");
        wait_term("vpa", 60);
        chk("vpa_ack_after_vma", ack_cyc - vma_cyc, 10);
        chk("vpa_ack_count", ack_cnt - a0, 1);
        chk("vpa_iornw_write", 32'(IORnW), 32'd0);
        idle_inputs();
        wait_idle("vpa");

        // BERR and DTACK together: error wins
        @(negedge CLK);
        ASActive = 1; IACS = 1; nWE = 1;
        a0 = ack_cnt; b0 = berr_cnt;
        wait_strobe("prio");
        @(negedge CLK);
        nIOBERR = 0; nIODTACK = 0;
        wait_term("prio", 40);
        chk("prio_berr_count", berr_cnt - b0, 1);
        chk("prio_no_ack", ack_cnt - a0, 0);
        idle_inputs();
        wait_idle("prio");

        // Re-trigger guard with ASActive held after the ack
        @(negedge CLK);
        ASActive = 1; IOCS = 1; nWE = 1;
        a0 = ack_cnt;
        wait_strobe("retrig");
        nIODTACK = 0;
        wait_term("retrig", 40);
        nIODTACK = 1;
        repeat (20) @(negedge CLK);
        chk("retrig_still_busy", 32'(IOBusy), 32'd1);
        chk("retrig_single_ack", ack_cnt - a0, 1);
        ASActive = 0; IOCS = 0;
        @(negedge CLK);
        chk("retrig_release", 32'(IOBusy), 32'd0);

        // No terminator at all
        @(negedge CLK);
        ASActive = 1; IOCS = 1; nWE = 1;
        a0 = ack_cnt; b0 = berr_cnt;
        wait_strobe("tmo");
`ifdef IOB_TIMEOUT_EN
        wait_term("tmo", 400);
        chk("timeout_latency", berr_cyc - strobe_cyc, TIMEOUT);
        chk("timeout_berr_count", berr_cnt - b0, 1);
`else
        repeat (1000) @(negedge CLK);
        chk("no_timeout_strobes", 32'({nIOAS, nIODS}), 32'd0);
        chk("no_timeout_no_term", (ack_cnt - a0) + (berr_cnt - b0), 0);
        nIODTACK = 0;
        wait_term("tmo", 40);
        chk("no_timeout_late_ack", ack_cnt - a0, 1);
`endif
        idle_inputs();
        wait_idle("tmo");

        // Reset in the middle of WAIT
        @(negedge CLK);
        ASActive = 1; IOCS = 1; nWE = 1;
        wait_strobe("rst");
        repeat (2) @(negedge CLK);
        a0 = ack_cnt; b0 = berr_cnt;
        @(posedge CLK);
        #3 nRES = 0;
        #1 chk("reset_mid_outputs", 32'({nIOAS, nIODS, nVMA, E, IOBusy}), 32'h1C);
        idle_inputs();
        repeat (3) @(negedge CLK);
        chk("reset_mid_no_term", (ack_cnt - a0) + (berr_cnt - b0), 0);
        nRES = 1;
        @(negedge CLK);
        ASActive = 1; IOCS = 1; nWE = 1;
        a0 = ack_cnt;
        wait_strobe("post_rst");
        nIODTACK = 0;
        wait_term("post_rst", 40);
        chk("post_rst_ack", ack_cnt - a0, 1);
        idle_inputs();
        wait_idle("post_rst");

        // Randomized transactions: DTACK / VPA / BERR / BERR+DTACK
        for (int t = 0; t < 30; t++) begin
            mode = $urandom_range(0, 3);
            dly  = $urandom_range(0, 6);
            drop = 1'($urandom_range(0, 1));
            sel  = 2'($urandom_range(1, 3));
            @(negedge CLK);
            ASActive = 1; IOCS = sel[0]; IACS = sel[1];
            nWE = 1'($urandom_range(0, 1));
            if (mode == 1) nIOVPA = 0;
            wait_strobe("rand");
            repeat (dly) @(negedge CLK);
            if (drop) ASActive = 0;
            case (mode)
                0: nIODTACK = 0;
                2: nIOBERR = 0;
                3: begin nIOBERR = 0; nIODTACK = 0; end
                default: ;
            endcase
            wait_term("rand", 300);
            repeat ($urandom_range(0, 3)) @(negedge CLK);
            idle_inputs();
            wait_idle("rand");
            repeat ($urandom_range(0, 3)) @(negedge CLK);
        end

        repeat (3) @(negedge CLK);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/iob_cycle_seq.md
Name: iob_cycle_seq

Overview:
- Downstream consumer of the chip-select decode. Takes the decoded IOCS/IACS from the FSB domain and runs a slow, 68000-style bus cycle on the I/O bus (SCSI, SCC, IWM, VIA, IACK).
- Generates the I/O-bus strobes and the E clock used for VPA/VIA cycles. Returns a single-cycle acknowledge or bus-error to the FSB cycle controller.

Parameters:
- SETUP_CYC, 2, CLK cycles between request capture and strobe assertion (address setup); range 1..15.
- E_DIV, 10, E clock period in CLK cycles.
- E_HIGH, 4, CLK cycles per period that E is high (E high when ECnt >= E_DIV-E_HIGH).
- TIMEOUT, 255, CLK cycles in WAIT before bus error (used only with IOB_TIMEOUT_EN); 8-bit.

Ports:
- CLK  in  1  system clock
- nRES  in  1  asynchronous active-low reset
- ASActive  in  1  FSB address strobe active, address/nWE valid
- IOCS  in  1  I/O-domain select from decode
- IACS  in  1  interrupt-acknowledge select from decode
- nWE  in  1  FSB write (0 = write)
- nIODTACK  in  1  I/O-bus data acknowledge, asynchronous
- nIOVPA  in  1  I/O-bus valid peripheral address, asynchronous
- nIOBERR  in  1  I/O-bus error, asynchronous
- nIOAS  out  1  I/O address strobe
- nIODS  out  1  I/O data strobe
- IORnW  out  1  I/O read/write (1 = read)
- nVMA  out  1  valid memory address for E-clock cycles
- E  out  1  E clock, free-running
- IOACK  out  1  one-cycle pulse: I/O cycle completed OK
- IOBERR  out  1  one-cycle pulse: I/O cycle terminated with error
- IOBusy  out  1  high from capture through RECOVER

Behaviour:
- Reset (async, nRES=0): state IDLE; nIOAS=nIODS=nVMA=1; IORnW=1; IOACK=IOBERR=IOBusy=0; ECnt=0, E=0; all synchronisers cleared. Mid-cycle reset drops strobes immediately, with no ack.
- nIODTACK, nIOVPA and nIOBERR each pass through a 2-FF synchroniser; "seen" means the synchronised value is 0.
- E: ECnt counts 0..E_DIV-1 and wraps. E registered; E=1 when ECnt >= E_DIV-E_HIGH. E falling edge = cycle in which ECnt wraps to 0. Runs regardless of state.
- IDLE: on ASActive && (IOCS||IACS), latch IORnW <= nWE, set IOBusy=1, load SetupCnt, go to SETUP. Capture takes one cycle; IORnW is valid from the cycle after capture.
- SETUP: count SETUP_CYC cycles, then assert nIOAS=0 and nIODS=0 together, clear the timeout counter, go to WAIT.
  - Read and write are timed identically; IORnW is held stable through RECOVER.
- WAIT: priority BERR > DTACK > VPA, evaluated each cycle.
  - BERR seen: go to END with err=1.
  - DTACK seen: go to END with err=0.
  - VPA seen (no DTACK): go to VPA1.
- VPA1: wait for the cycle where E is low and ECnt==0, then assert nVMA=0 and go to VPA2. This aligns to the start of a full E period.
- VPA2: wait for the next E falling edge (ECnt wraps), then go to END with err=0. BERR seen here also goes to END with err=1.
- END (1 cycle): nIOAS=nIODS=nVMA=1; pulse IOACK (err=0) or IOBERR (err=1); go to RECOVER.
- RECOVER: hold until ASActive=0 AND synchronised nIODTACK=nIOVPA=1; then IOBusy=0, go to IDLE. This prevents re-triggering on the same FSB cycle.
- IOACK and IOBERR are never high in the same cycle. Each pulses exactly once per captured cycle.
- Requests during IOBusy are ignored. The FSB is stalled by the absence of IOACK.
- ASActive dropping before END: the I/O cycle still completes normally; the ack pulse is still produced.

Optional Feature:
- IOB_TIMEOUT_EN defined: an 8-bit counter runs in WAIT, VPA1 and VPA2.
  - On reaching TIMEOUT with no terminator, go to END with err=1 (IOBERR pulse).
  - Counter cleared on entering WAIT.
- IOB_TIMEOUT_EN undefined: counter absent; the sequencer waits indefinitely for DTACK/VPA/BERR.

Test Plan:
- Read with DTACK: ASActive=1, IOCS=1, nWE=1; nIODTACK=0 at 5 cycles after strobes -> nIOAS/nIODS low 2 cycles after capture, IORnW=1, IOACK single pulse at sync latency (2) + 1 cycle after DTACK, IOBERR=0.
- VIA write via VPA: IOCS=1, nWE=0, nIOVPA=0 held -> IORnW=0; nVMA asserts at ECnt==0; strobes release and IOACK pulses on the following E wrap (10 cycles later at E_DIV=10).
- Priority: nIOBERR and nIODTACK asserted in the same cycle -> IOBERR pulse, no IOACK.
- Re-trigger guard: ASActive held high 20 cycles after IOACK -> stays in RECOVER, IOBusy=1, no second cycle; ASActive=0 -> IOBusy=0 one cycle later.
- Timeout (IOB_TIMEOUT_EN defined): no terminator -> IOBERR pulse 255 cycles after strobe assertion. Undefined: still in WAIT after 1000 cycles.
- Reset mid-cycle: nRES=0 during WAIT -> nIOAS=nIODS=1 immediately, E=0, no IOACK/IOBERR; normal read completes after release.
